// File: rtl/ksa_pipelined_adder.sv
// Kogge-Stone prefix adder with optional pipeline registers after any prefix
// level (selected by PIPE_MASK), a mandatory output register, and a
// valid/ready handshake with global-stall back-pressure.
module ksa_pipelined_adder #(
  parameter int                WIDTH     = 32,
  parameter int                LEVELS    = $clog2(WIDTH),
  parameter logic [LEVELS-1:0] PIPE_MASK = LEVELS'(5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Every stage advances together; a held output freezes the whole pipe.
  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  logic [WIDTH-1:0] g_pre;
  logic [WIDTH-1:0] p_pre;

  // Pre-processing: bitwise generate/propagate, carry-in folded into bit 0.
  always_comb begin
    p_pre    = a ^ b;
    g_pre    = a & b;
    g_pre[0] = (a[0] & b[0]) | (p_pre[0] & cin);
  end

  // stg[0] is the pre-processed operand set; stg[lv] is the output of prefix
  // level lv, either straight through or from a register.
  for (genvar lv = 0; lv <= LEVELS; lv++) begin : stg
    logic [WIDTH-1:0] g_o;
    logic [WIDTH-1:0] p_o;
    logic [WIDTH-1:0] pp_o;
    logic             am_o;
    logic             bm_o;
    logic             cin_o;
    logic             vld_o;

    if (lv == 0) begin : g_in
      assign g_o   = g_pre;
      assign p_o   = p_pre;
      assign pp_o  = p_pre;
      assign am_o  = a[WIDTH-1];
      assign bm_o  = b[WIDTH-1];
      assign cin_o = cin;
      assign vld_o = in_valid & in_ready;
    end else begin : g_lvl
      localparam int D = 1 << (lv - 1);
      logic [WIDTH-1:0] g_c;
      logic [WIDTH-1:0] p_c;

      // Black cells at distance D; bits below D pass through unchanged.
      always_comb begin
        g_c = stg[lv-1].g_o;
        p_c = stg[lv-1].p_o;
        for (int i = D; i < WIDTH; i++) begin
          g_c[i] = stg[lv-1].g_o[i] | (stg[lv-1].p_o[i] & stg[lv-1].g_o[i-D]);
          p_c[i] = stg[lv-1].p_o[i] & stg[lv-1].p_o[i-D];
        end
      end

      if (PIPE_MASK[lv-1]) begin : g_reg
        logic [WIDTH-1:0] g_p;
        logic [WIDTH-1:0] p_p;
        logic [WIDTH-1:0] pp_p;
        logic             am_p;
        logic             bm_p;
        logic             cin_p;
        logic             vld_p;

        // ---- pipeline boundary after this prefix level ----
        // Data register: no reset, loads whenever the pipe advances.
        always_ff @(posedge clk) begin
          if (en) begin
            g_p   <= g_c;
            p_p   <= p_c;
            pp_p  <= stg[lv-1].pp_o;
            am_p  <= stg[lv-1].am_o;
            bm_p  <= stg[lv-1].bm_o;
            cin_p <= stg[lv-1].cin_o;
          end
        end

        // Valid bit travels with the data; reset flushes in-flight work.
        always_ff @(posedge clk) begin
          if (rst)     vld_p <= 1'b0;
          else if (en) vld_p <= stg[lv-1].vld_o;
        end

        assign g_o   = g_p;
        assign p_o   = p_p;
        assign pp_o  = pp_p;
        assign am_o  = am_p;
        assign bm_o  = bm_p;
        assign cin_o = cin_p;
        assign vld_o = vld_p;
      end else begin : g_thru
        assign g_o   = g_c;
        assign p_o   = p_c;
        assign pp_o  = stg[lv-1].pp_o;
        assign am_o  = stg[lv-1].am_o;
        assign bm_o  = stg[lv-1].bm_o;
        assign cin_o = stg[lv-1].cin_o;
        assign vld_o = stg[lv-1].vld_o;
      end
    end
  end

  // Group propagate of the last level has no consumer.
  logic unused_p_last;
  assign unused_p_last = &{1'b0, stg[LEVELS].p_o};

  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  // Post-processing: carry into bit i is the group generate of bits i-1..0.
  always_comb begin
    sum_c  = stg[LEVELS].pp_o ^ {stg[LEVELS].g_o[WIDTH-2:0], stg[LEVELS].cin_o};
    cout_c = stg[LEVELS].g_o[WIDTH-1];
    ovf_c  = (stg[LEVELS].am_o == stg[LEVELS].bm_o) &
             (sum_c[WIDTH-1] != stg[LEVELS].am_o);
  end

  // ---- output register boundary ----
  // Result only loads with a valid op, so bubbles never expose unset data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= stg[LEVELS].vld_o;
      if (stg[LEVELS].vld_o) begin
        sum  <= sum_c;
        cout <= cout_c;
        ovf  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_ksa_pipelined_adder.sv
// Directed bench for ksa_pipelined_adder: 32-bit pipelined instance (N=3)
// and an 8-bit purely combinational-tree instance (N=1).
module tb_ksa_pipelined_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [31:0] a, b, sum;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  ksa_pipelined_adder #(.WIDTH(32), .PIPE_MASK(5'b00101)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  ksa_pipelined_adder #(.WIDTH(8), .PIPE_MASK(3'b000)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    res_t r;
    t   = {1'b0, x} + {1'b0, y} + 33'(ci);
    r.s = t[31:0];
    r.c = t[32];
    r.o = (x[31] == y[31]) && (t[31] != x[31]);
    return r;
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    logic [8:0] t;
    t = {1'b0, x} + {1'b0, y} + 9'(ci);
    return {t[7:0], t[8], (x[7] == y[7]) && (t[7] != x[7])};
  endfunction

  // Scoreboard for streamed traffic on the 32-bit instance.
  res_t expq[$];
  bit   trk_en = 1'b0;
  int   got = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;

  // Record every accepted operand set.
  always @(negedge clk)
    if (trk_en && !rst && in_valid && in_ready) expq.push_back(model(a, b, cin));

  // Compare every delivered result against the oldest outstanding one.
  always @(negedge clk) begin
    res_t e;
    if (trk_en && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stream_extra: got %h expected no result", {sum, cout, ovf});
      end else begin
        e = expq.pop_front();
        chk("stream_result", 64'({sum, cout, ovf}), 64'(e));
        got++;
        if (got == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  end

  // Drive one operand set (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c);
    bit acc;
    int w;
    acc = 1'b0;
    w   = 0;
    in_valid = 1'b1; a = x; b = y; cin = c;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      w++;
    end while (!acc && w < 50);
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance within 50 cycles");
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        ci;
    logic [31:0] s;
    logic        co, ov;
  } vec_t;

  vec_t tbl[10];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    tbl[4] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};
    tbl[7] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[8] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[9] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum",       64'(sum),       64'(0));
    chk("rst_cout",      64'(cout),      64'(0));
    chk("rst_ovf",       64'(ovf),       64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst8_out_valid", 64'(out_valid8), 64'(0));

    // Directed table: single operations with latency and value checks
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; cin = tbl[i].ci;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        if (out_valid) begin
          lat = k;
          break;
        end
        @(posedge clk); #1;
      end
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(3));
      chk($sformatf("tbl%0d_sum", i),  64'(sum),  64'(tbl[i].s));
      chk($sformatf("tbl%0d_cout", i), 64'(cout), 64'(tbl[i].co));
      chk($sformatf("tbl%0d_ovf", i),  64'(ovf),  64'(tbl[i].ov));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_single", i), 64'(out_valid), 64'(0));
    end

    // Back-to-back stream of 8 operations
    trk_en = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    for (int k = 0; k < 30 && got < 8; k++) @(negedge clk);
    chk("b2b_count", 64'(got), 64'(8));
    chk("b2b_consecutive", 64'(last_cyc - first_cyc), 64'(7));
    chk("b2b_drained", 64'(expq.size()), 64'(0));

    // Stall with full pipe
    @(posedge clk); #1;
    got = 0;
    out_ready = 1'b0;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    send(32'h8000_0001, 32'h8000_0001, 1'b1);
    send(32'h7FFF_0000, 32'h0001_0000, 1'b0);
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h2152_4111; cin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_in_ready",  64'(in_ready),  64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      chk("stall_result",    64'({sum, cout, ovf}), 64'(model(32'h0000_00FF, 32'h0000_0001, 1'b0)));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 30 && got < 4; k++) @(negedge clk);
    chk("stall_delivered", 64'(got), 64'(4));
    chk("stall_drained", 64'(expq.size()), 64'(0));

    // Reset with operations in flight
    @(posedge clk); #1;
    send(32'h1111_1111, 32'h2222_2222, 1'b0);
    send(32'h4444_4444, 32'h4444_4444, 1'b1);
    send(32'hFFFF_0000, 32'h0001_FFFF, 1'b1);
    in_valid = 1'b0;
    trk_en = 1'b0;
    expq.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("inflight_rst_out_valid", 64'(out_valid), 64'(0));
    chk("inflight_rst_sum",       64'(sum),       64'(0));
    chk("inflight_rst_cout",      64'(cout),      64'(0));
    chk("inflight_rst_ovf",       64'(ovf),       64'(0));
    chk("inflight_rst_in_ready",  64'(in_ready),  64'(1));
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("no_stale_result", 64'(out_valid), 64'(0));
    end

    // 8-bit instance, latency 1, all a and cin against a spread of b
    in_valid8 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int x = 0; x < 256; x++) begin
        for (int y = 0; y < 256; y += 3) begin
          a8 = 8'(x); b8 = 8'(y); cin8 = 1'(c);
          @(posedge clk); #1;
          chk("w8_vector", 64'({out_valid8, sum8, cout8, ovf8}),
              64'({1'b1, model8(8'(x), 8'(y), 1'(c))}));
        end
      end
    end
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("w8_cin_only", 64'({out_valid8, sum8, cout8, ovf8}), 64'({1'b1, 8'h01, 1'b0, 1'b0}));
    @(posedge clk); #1;
    chk("w8_bubble", 64'(out_valid8), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
